lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Parametrised load/store unit and data memory that replaces the fixed single-cycle data memory in the pipelined RV32 core.
- Sits at the MEM stage.
- Supports byte, half and word accesses with sign and zero extension, configurable wait states, and misalignment detection.
- Provides a valid/ready request port and a stall output that the hazard unit uses to freeze F/D/E/M while an access is in flight.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words of storage; must be a power of 2, minimum 4.
- WAIT_STATES, 2, extra cycles of access latency; legal range 0..15.
- ADDR_W, 32, width of the byte address input.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising edge of clk).
- req_valid  input  1  MEM stage presents an access.
- req_ready  output  1  unit can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32 funct3 size/sign code.
- req_addr  input  ADDR_W  byte address (ALUResultM).
- req_wdata  input  32  store data (writeDataM); low bits used for SB/SH.
- rsp_valid  output  1  one-cycle pulse: access complete.
- rsp_rdata  output  32  extended load data.
- rsp_err  output  1  valid with rsp_valid: misaligned or illegal funct3.
- stall  output  1  high while a request is in flight.

Behaviour:
- FSM states: IDLE, WAIT, RESP.
- Output decodes: req_ready = (state==IDLE); stall = (state!=IDLE); rsp_valid = (state==RESP).
- Reset (reset==0 at an edge):
  - state goes to IDLE, wait counter to 0, rsp_rdata to 0, rsp_err to 0.
  - Any in-flight access is abandoned; a pending store is NOT written.
  - Memory array contents are preserved.
- IDLE:
  - On req_valid at an edge, latch we/funct3/addr/wdata, load the counter with WAIT_STATES, and go to WAIT.
  - Without req_valid, stay in IDLE.
- WAIT:
  - If counter != 0, decrement it and stay.
  - If counter == 0, perform the access at this edge and go to RESP.
- RESP:
  - Lasts exactly one cycle, then returns to IDLE.
  - No request is accepted in RESP.
- Latency: with acceptance at edge E0, rsp_valid is high in the cycle following edge E0+WAIT_STATES+1. Minimum request spacing is WAIT_STATES+3 cycles.
- Word index = addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
- Loads:
  - 000 LB: sign-extend the byte selected by addr[1:0].
  - 001 LH: sign-extend the half selected by addr[1].
  - 010 LW: full word.
  - 100 LBU / 101 LHU: zero-extend.
- Stores (only the addressed byte lanes are written):
  - 000 SB: wdata[7:0] to the lane at addr[1:0].
  - 001 SH: wdata[15:0] to the lanes at addr[1].
  - 010 SW: all four lanes.
- Error cases, all of which give no memory write, rsp_err=1 and rsp_rdata=0:
  - Misaligned access: half with addr[0]=1, or word with addr[1:0]!=0.
  - Illegal funct3: loads 011/110/111; stores anything other than 000/001/010.
- rsp_rdata and rsp_err update only at the WAIT-to-RESP edge:
  - Successful store: rsp_rdata = 0, rsp_err = 0.
  - Both hold their value until the next response.
- req_* inputs are ignored outside IDLE; changes after acceptance have no effect.

Optional Feature:
- Macro: LSU_PERF_CNT_EN.
- When defined, three extra outputs are added: load_cnt[31:0], store_cnt[31:0] and err_cnt[31:0].
  - The matching counter increments by 1 at the WAIT-to-RESP edge for a successful load, a successful store, or an errored access.
  - All three clear to 0 on reset and wrap from 0xFFFFFFFF to 0.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
1. WAIT_STATES=2: SW addr=0x10 wdata=0xDEADBEEF, then LW 0x10 -> each rsp_valid rises 4 cycles after acceptance; stall is high for 4 cycles; the LW returns 0xDEADBEEF with rsp_err=0.
2. Mem[0x20]=0x8070F0FF: LB 0x21 -> 0xFFFFFFF0; LBU 0x21 -> 0x000000F0; LH 0x22 -> 0xFFFF8070; LHU 0x22 -> 0x00008070.
3. Word 0x30 = 0x11223344:
   - SB 0x33 wdata=0xAB, then LW 0x30 -> 0xAB223344.
   - SH 0x30 wdata=0xCAFE, then LW 0x30 -> 0xAB22CAFE.
4. LW 0x06, SH 0x11, and a load with funct3=011 -> each gives rsp_err=1 and rsp_rdata=0, and memory is unchanged (readback of the affected word matches its prior value).
5. DEPTH_WORDS=256: SW 0x400 wdata=0x5 -> LW 0x0 returns 0x5 (wrap). With WAIT_STATES=0 -> rsp_valid in the 2nd cycle after acceptance.
6. Reset pulsed low during WAIT of SW 0x40 wdata=0x1 (prior value 0x9):
   - Next cycle: state IDLE, stall=0, rsp_valid never asserted.
   - LW 0x40 -> 0x9.
   - With LSU_PERF_CNT_EN: counters read 0 after reset, and reach load_cnt=1, store_cnt=0, err_cnt=0 after the LW.

Source files
------------

// File: rtl/lsu_mem_ctrl_if.sv
// Request/response bus between the MEM stage and the load/store unit.
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; req_* must be stable in that cycle and are
// ignored at every other time. rsp_valid is a one-cycle pulse with no
// back-pressure, and rsp_rdata/rsp_err hold until the next response.
interface lsu_mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              stall;
    logic [1:0]        dbg_state;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall, dbg_state
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, stall, dbg_state
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit with private data memory for the MEM stage of the RV32 core.
// Byte/half/word accesses with sign/zero extension, WAIT_STATES extra cycles
// of latency, and misalignment / illegal-funct3 detection.
// Optional macro LSU_PERF_CNT_EN adds load/store/error event counters.
module lsu_mem_ctrl #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2,
    parameter int ADDR_W      = 32
) (
    input  logic                clk,
    input  logic                reset,
    lsu_mem_ctrl_if.slave       bus
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [31:0]         load_cnt,
    output logic [31:0]         store_cnt,
    output logic [31:0]         err_cnt
`endif
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int AW    = IDX_W + 2;
    localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [31:0]   mem_q [DEPTH_WORDS];

    // Upper address bits only alias the storage, so they are dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[ADDR_W-1:AW];

    logic [IDX_W-1:0] idx;
    logic [31:0]      rd_word;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      ld_data;
    logic             acc_err;
    logic [3:0]       wr_be;
    logic [31:0]      wr_data;
    logic             mem_wr;

    assign idx     = addr_q[AW-1:2];
    assign rd_word = mem_q[idx];

    // Decode the latched access: error check, load extraction, store lanes.
    always_comb begin
        acc_err = 1'b0;
        ld_byte = 8'h00;
        ld_half = 16'h0000;
        ld_data = 32'h0;
        wr_be   = 4'b0000;
        wr_data = 32'h0;
        if (we_q) begin
            acc_err = (funct3_q != 3'b000) && (funct3_q != 3'b001) && (funct3_q != 3'b010);
        end else begin
            acc_err = (funct3_q == 3'b011) || (funct3_q == 3'b110) || (funct3_q == 3'b111);
        end
        if ((funct3_q[1:0] == 2'b01) && addr_q[0]) acc_err = 1'b1;
        if ((funct3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00)) acc_err = 1'b1;

        case (addr_q[1:0])
            2'd0:    ld_byte = rd_word[7:0];
            2'd1:    ld_byte = rd_word[15:8];
            2'd2:    ld_byte = rd_word[23:16];
            default: ld_byte = rd_word[31:24];
        endcase
        ld_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
        case (funct3_q[1:0])
            2'b00:   ld_data = funct3_q[2] ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = funct3_q[2] ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_data = rd_word;
        endcase

        case (funct3_q[1:0])
            2'b00: begin
                wr_be   = 4'b0001 << addr_q[1:0];
                wr_data = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                wr_be   = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{wdata_q[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_data = wdata_q;
            end
        endcase
    end

`ifdef LSU_PERF_CNT_EN
    logic [31:0] load_cnt_q, load_cnt_d;
    logic [31:0] store_cnt_q, store_cnt_d;
    logic [31:0] err_cnt_q, err_cnt_d;
    assign load_cnt  = load_cnt_q;
    assign store_cnt = store_cnt_q;
    assign err_cnt   = err_cnt_q;
`endif

    // Next-state: IDLE accepts, WAIT counts down then performs the access, RESP pulses once.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        mem_wr   = 1'b0;
`ifdef LSU_PERF_CNT_EN
        load_cnt_d  = load_cnt_q;
        store_cnt_d = store_cnt_q;
        err_cnt_d   = err_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    we_d     = bus.req_we;
                    funct3_d = bus.req_funct3;
                    addr_d   = bus.req_addr[AW-1:0];
                    wdata_d  = bus.req_wdata;
                    cnt_d    = WS_INIT;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_RESP;
                    err_d   = acc_err;
                    rdata_d = (acc_err || we_q) ? 32'h0 : ld_data;
                    mem_wr  = we_q && !acc_err;
`ifdef LSU_PERF_CNT_EN
                    if (acc_err)   err_cnt_d   = err_cnt_q + 32'd1;
                    else if (we_q) store_cnt_d = store_cnt_q + 32'd1;
                    else           load_cnt_d  = load_cnt_q + 32'd1;
`endif
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control and response registers; reset abandons any in-flight access.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
`ifdef LSU_PERF_CNT_EN
            load_cnt_q  <= 32'h0;
            store_cnt_q <= 32'h0;
            err_cnt_q   <= 32'h0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
`ifdef LSU_PERF_CNT_EN
            load_cnt_q  <= load_cnt_d;
            store_cnt_q <= store_cnt_d;
            err_cnt_q   <= err_cnt_d;
`endif
        end
    end

    // Storage keeps its contents across reset; only addressed lanes are written.
    always_ff @(posedge clk) begin
        if (reset && mem_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) mem_q[idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.stall     = (state_q != S_IDLE);
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: a vector table on a WAIT_STATES=2 unit,
// plus hand sequences for reset-during-access and a WAIT_STATES=0 unit.
module tb_lsu_mem_ctrl;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    lsu_mem_ctrl_if #(.ADDR_W(32)) bus0 ();
    lsu_mem_ctrl_if #(.ADDR_W(32)) bus1 ();

`ifdef LSU_PERF_CNT_EN
    logic [31:0] load_cnt0, store_cnt0, err_cnt0;
    logic [31:0] load_cnt1, store_cnt1, err_cnt1;
`endif

    lsu_mem_ctrl #(.DEPTH_WORDS(256), .WAIT_STATES(2), .ADDR_W(32)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
`ifdef LSU_PERF_CNT_EN
        ,
        .load_cnt  (load_cnt0),
        .store_cnt (store_cnt0),
        .err_cnt   (err_cnt0)
`endif
    );

    lsu_mem_ctrl #(.DEPTH_WORDS(256), .WAIT_STATES(0), .ADDR_W(32)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
`ifdef LSU_PERF_CNT_EN
        ,
        .load_cnt  (load_cnt1),
        .store_cnt (store_cnt1),
        .err_cnt   (err_cnt1)
`endif
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic add(input string name, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.name = name; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        vecs.push_back(v);
    endtask

    // Drive one request on the chosen unit and wait (bounded) for its response.
    // lat = number of cycles after the acceptance edge at which rsp_valid is seen.
    task automatic do_access(input bit use1, input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rdata, output logic err,
                             output int lat, output int stall_cyc);
        @(negedge clk);
        if (use1) begin
            bus1.req_valid = 1'b1; bus1.req_we = we; bus1.req_funct3 = f3;
            bus1.req_addr = addr; bus1.req_wdata = wdata;
        end else begin
            bus0.req_valid = 1'b1; bus0.req_we = we; bus0.req_funct3 = f3;
            bus0.req_addr = addr; bus0.req_wdata = wdata;
        end
        @(posedge clk);
        lat = 0;
        stall_cyc = 0;
        rdata = 32'hxxxx_xxxx;
        err = 1'bx;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                // Scramble the request after acceptance; it must be ignored.
                if (use1) begin
                    bus1.req_valid = 1'b0; bus1.req_we = ~we; bus1.req_funct3 = 3'b010;
                    bus1.req_addr = $urandom_range(0, 255) * 4; bus1.req_wdata = $urandom;
                end else begin
                    bus0.req_valid = 1'b0; bus0.req_we = ~we; bus0.req_funct3 = 3'b010;
                    bus0.req_addr = $urandom_range(0, 255) * 4; bus0.req_wdata = $urandom;
                end
            end
            if (use1 ? bus1.stall : bus0.stall) stall_cyc++;
            if (use1 ? bus1.rsp_valid : bus0.rsp_valid) begin
                lat   = c;
                rdata = use1 ? bus1.rsp_rdata : bus0.rsp_rdata;
                err   = use1 ? bus1.rsp_err : bus0.rsp_err;
                break;
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          stc;
        int          rv_seen;
        int          exp_ld;
        int          exp_st;
        int          exp_er;

        n_checks = 0;
        n_pass   = 0;
        exp_ld = 0; exp_st = 0; exp_er = 0;

        // Vector table: {name, we, funct3, addr, wdata, expected rdata, expected err}
        add("sw_10",      1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        0);
        add("lw_10",      0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 0);
        add("sw_20",      1, 3'b010, 32'h20,  32'h8070F0FF, 32'h0,        0);
        add("lb_21",      0, 3'b000, 32'h21,  32'h0,        32'hFFFFFFF0, 0);
        add("lbu_21",     0, 3'b100, 32'h21,  32'h0,        32'h000000F0, 0);
        add("lh_22",      0, 3'b001, 32'h22,  32'h0,        32'hFFFF8070, 0);
        add("lhu_22",     0, 3'b101, 32'h22,  32'h0,        32'h00008070, 0);
        add("lb_23",      0, 3'b000, 32'h23,  32'h0,        32'hFFFFFF80, 0);
        add("lhu_20",     0, 3'b101, 32'h20,  32'h0,        32'h0000F0FF, 0);
        add("sw_30",      1, 3'b010, 32'h30,  32'h11223344, 32'h0,        0);
        add("sb_33",      1, 3'b000, 32'h33,  32'hFFFFFFAB, 32'h0,        0);
        add("lw_30_sb",   0, 3'b010, 32'h30,  32'h0,        32'hAB223344, 0);
        add("sh_30",      1, 3'b001, 32'h30,  32'h1234CAFE, 32'h0,        0);
        add("lw_30_sh",   0, 3'b010, 32'h30,  32'h0,        32'hAB22CAFE, 0);
        add("sw_04",      1, 3'b010, 32'h04,  32'hA5A5A5A5, 32'h0,        0);
        add("lw_06_mis",  0, 3'b010, 32'h06,  32'h0,        32'h0,        1);
        add("lw_04_keep", 0, 3'b010, 32'h04,  32'h0,        32'hA5A5A5A5, 0);
        add("sh_11_mis",  1, 3'b001, 32'h11,  32'h0000BEEF, 32'h0,        1);
        add("lw_10_keep", 0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 0);
        add("ld_f3_011",  0, 3'b011, 32'h30,  32'h0,        32'h0,        1);
        add("st_f3_100",  1, 3'b100, 32'h30,  32'h0,        32'h0,        1);
        add("lw_30_keep", 0, 3'b010, 32'h30,  32'h0,        32'hAB22CAFE, 0);
        add("sw_400",     1, 3'b010, 32'h400, 32'h00000005, 32'h0,        0);
        add("lw_0_wrap",  0, 3'b010, 32'h0,   32'h0,        32'h00000005, 0);
        add("sw_40",      1, 3'b010, 32'h40,  32'h00000009, 32'h0,        0);

        // Reset block
        reset = 1'b0;
        bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_funct3 = 3'b0;
        bus0.req_addr = 32'h0; bus0.req_wdata = 32'h0;
        bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_funct3 = 3'b0;
        bus1.req_addr = 32'h0; bus1.req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready",  32'(bus0.req_ready), 32'd1);
        check("rst_stall",  32'(bus0.stall),     32'd0);
        check("rst_rvalid", 32'(bus0.rsp_valid), 32'd0);
        check("rst_rdata",  bus0.rsp_rdata,      32'h0);
        check("rst_err",    32'(bus0.rsp_err),   32'd0);
        check("rst_state",  32'(bus0.dbg_state), 32'd0);
        reset = 1'b1;

        // Table loop
        foreach (vecs[i]) begin
            do_access(1'b0, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, lat, stc);
            check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
            check({vecs[i].name, "_err"},   32'(er), 32'(vecs[i].exp_err));
            check({vecs[i].name, "_lat"},   32'(lat), 32'd4);
            check({vecs[i].name, "_stall"}, 32'(stc), 32'd4);
            if (vecs[i].exp_err) exp_er++;
            else if (vecs[i].we) exp_st++;
            else exp_ld++;
        end
        // Response holds after the RESP cycle
        @(negedge clk);
        check("hold_rvalid", 32'(bus0.rsp_valid), 32'd0);
        check("hold_stall",  32'(bus0.stall),     32'd0);
`ifdef LSU_PERF_CNT_EN
        check("perf_load",  load_cnt0,  32'(exp_ld));
        check("perf_store", store_cnt0, 32'(exp_st));
        check("perf_err",   err_cnt0,   32'(exp_er));
`endif

        // Reset asserted at the edge where SW 0x40 <- 1 would be written
        @(negedge clk);
        bus0.req_valid = 1'b1; bus0.req_we = 1'b1; bus0.req_funct3 = 3'b010;
        bus0.req_addr = 32'h40; bus0.req_wdata = 32'h1;
        @(posedge clk);
        @(negedge clk);
        bus0.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_state",  32'(bus0.dbg_state), 32'd0);
        check("abort_stall",  32'(bus0.stall),     32'd0);
        check("abort_rvalid", 32'(bus0.rsp_valid), 32'd0);
        check("abort_rdata",  bus0.rsp_rdata,      32'h0);
`ifdef LSU_PERF_CNT_EN
        check("abort_load_cnt",  load_cnt0,  32'h0);
        check("abort_store_cnt", store_cnt0, 32'h0);
        check("abort_err_cnt",   err_cnt0,   32'h0);
`endif
        reset = 1'b1;
        rv_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus0.rsp_valid) rv_seen++;
        end
        check("abort_no_rsp", 32'(rv_seen), 32'd0);
        do_access(1'b0, 1'b0, 3'b010, 32'h40, 32'h0, rd, er, lat, stc);
        check("abort_lw40", rd, 32'h9);
        check("abort_lw40_err", 32'(er), 32'd0);
`ifdef LSU_PERF_CNT_EN
        check("after_load_cnt",  load_cnt0,  32'd1);
        check("after_store_cnt", store_cnt0, 32'd0);
        check("after_err_cnt",   err_cnt0,   32'd0);
`endif

        // Zero-wait-state unit
        do_access(1'b1, 1'b1, 3'b010, 32'h8, 32'h00000077, rd, er, lat, stc);
        check("ws0_sw_lat", 32'(lat), 32'd2);
        check("ws0_sw_err", 32'(er),  32'd0);
        do_access(1'b1, 1'b0, 3'b010, 32'h8, 32'h0, rd, er, lat, stc);
        check("ws0_lw_lat",   32'(lat), 32'd2);
        check("ws0_lw_rdata", rd,       32'h00000077);
        check("ws0_lw_stall", 32'(stc), 32'd2);
        do_access(1'b1, 1'b0, 3'b001, 32'h9, 32'h0, rd, er, lat, stc);
        check("ws0_lh_mis_err",   32'(er), 32'd1);
        check("ws0_lh_mis_rdata", rd,      32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
